// File: rtl/perceptron_accum.sv
// Perceptron dot-product accumulator with threshold compare and a valid/ready result port.
// Optional build macro ACCUM_SAT_EN: clamp the accumulator at 2^ACC_W-1 instead of wrapping.
module perceptron_accum #(
    parameter int NUM_INPUTS = 784,
    parameter int ACC_W      = 26
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [15:0]      product,
    input  logic             product_valid,
    output logic             in_ready,
    input  logic [ACC_W-1:0] threshold,
    output logic [ACC_W-1:0] sum,
    output logic             fire,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (NUM_INPUTS < 2 || ACC_W < 16) begin : g_bad_param
            $error("perceptron_accum: NUM_INPUTS must be >= 2 and ACC_W >= 16");
        end
    endgenerate

    localparam int CNT_W = $clog2(NUM_INPUTS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_INPUTS - 1);

    typedef enum logic {
        ACCUM,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             ovf_acc, ovf_acc_nx;
    logic [ACC_W-1:0] sum_nx;
    logic             fire_nx;
    logic             overflow_nx;
    logic [ACC_W:0]   add_full;
    logic             carry;
    logic [ACC_W-1:0] add_res;

    assign add_full = {1'b0, acc} + (ACC_W + 1)'(product);
    assign carry    = add_full[ACC_W];

`ifdef ACCUM_SAT_EN
    // Once clamped, any further nonzero product carries again, so acc stays at max.
    assign add_res = carry ? '1 : add_full[ACC_W-1:0];
`else
    assign add_res = add_full[ACC_W-1:0];
`endif

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ACCUM;
            acc      <= '0;
            count    <= '0;
            ovf_acc  <= 1'b0;
            sum      <= '0;
            fire     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            count    <= count_nx;
            ovf_acc  <= ovf_acc_nx;
            sum      <= sum_nx;
            fire     <= fire_nx;
            overflow <= overflow_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        count_nx    = count;
        ovf_acc_nx  = ovf_acc;
        sum_nx      = sum;
        fire_nx     = fire;
        overflow_nx = overflow;
        if (clear) begin
            state_nx    = ACCUM;
            acc_nx      = '0;
            count_nx    = '0;
            ovf_acc_nx  = 1'b0;
            overflow_nx = 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (product_valid) begin
                        if (count == LAST) begin
                            state_nx    = DONE;
                            sum_nx      = add_res;
                            fire_nx     = (add_res >= threshold);
                            overflow_nx = ovf_acc | carry;
                            acc_nx      = '0;
                            count_nx    = '0;
                            ovf_acc_nx  = 1'b0;
                        end else begin
                            acc_nx     = add_res;
                            count_nx   = count + 1'b1;
                            ovf_acc_nx = ovf_acc | carry;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nx    = ACCUM;
                        overflow_nx = 1'b0;
                    end
                end
                default: state_nx = ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_accum.sv
// Self-checking bench: three accumulator configurations against a queue-based arithmetic model.
module tb_perceptron_accum;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // A: NUM_INPUTS=4, ACC_W=26   B: NUM_INPUTS=2, ACC_W=16   C: defaults
    logic        a_clear = 0, a_pv = 0, a_ir, a_fire, a_ovf, a_ov, a_or = 0;
    logic [15:0] a_prod = 0;
    logic [25:0] a_thr = 0, a_sum;
    logic        b_clear = 0, b_pv = 0, b_ir, b_fire, b_ovf, b_ov, b_or = 0;
    logic [15:0] b_prod = 0;
    logic [15:0] b_thr = 0, b_sum;
    logic        c_clear = 0, c_pv = 0, c_ir, c_fire, c_ovf, c_ov, c_or = 0;
    logic [15:0] c_prod = 0;
    logic [25:0] c_thr = 0, c_sum;

    int checks = 0;
    int failures = 0;

    perceptron_accum #(.NUM_INPUTS(4), .ACC_W(26)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(a_clear), .product(a_prod),
        .product_valid(a_pv), .in_ready(a_ir), .threshold(a_thr), .sum(a_sum),
        .fire(a_fire), .overflow(a_ovf), .out_valid(a_ov), .out_ready(a_or));

    perceptron_accum #(.NUM_INPUTS(2), .ACC_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(b_clear), .product(b_prod),
        .product_valid(b_pv), .in_ready(b_ir), .threshold(b_thr), .sum(b_sum),
        .fire(b_fire), .overflow(b_ovf), .out_valid(b_ov), .out_ready(b_or));

    perceptron_accum dut_c (
        .clk(clk), .reset_n(reset_n), .clear(c_clear), .product(c_prod),
        .product_valid(c_pv), .in_ready(c_ir), .threshold(c_thr), .sum(c_sum),
        .fire(c_fire), .overflow(c_ovf), .out_valid(c_ov), .out_ready(c_or));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic beat(input int which, input logic [15:0] p);
        case (which)
            0: begin a_prod = p; a_pv = 1; end
            1: begin b_prod = p; b_pv = 1; end
            default: begin c_prod = p; c_pv = 1; end
        endcase
        tick();
        a_pv = 0; b_pv = 0; c_pv = 0;
    endtask

    // Reference: running unsigned sum of the vector, wrapped or clamped at 2^w.
    task automatic model(input int w, input logic [15:0] p[$], output longint s, output bit ov);
        longint lim;
        lim = (longint'(1) << w);
        s = 0;
        ov = 0;
        foreach (p[i]) begin
            s += longint'(p[i]);
            if (s >= lim) begin
                ov = 1;
`ifdef ACCUM_SAT_EN
                s = lim - 1;
`else
                s -= lim;
`endif
            end
        end
    endtask

    task automatic observe(input int which, output logic [63:0] s, output logic f,
                           output logic o, output logic v, output logic r);
        case (which)
            0: begin s = 64'(a_sum); f = a_fire; o = a_ovf; v = a_ov; r = a_ir; end
            1: begin s = 64'(b_sum); f = b_fire; o = b_ovf; v = b_ov; r = b_ir; end
            default: begin s = 64'(c_sum); f = c_fire; o = c_ovf; v = c_ov; r = c_ir; end
        endcase
    endtask

    task automatic set_ready(input int which, input logic v);
        case (which)
            0: a_or = v;
            1: b_or = v;
            default: c_or = v;
        endcase
    endtask

    // Drive one vector, check the result (and an optional anchored sum), hold under
    // backpressure with spurious beats, then release it.
    task automatic run_vec(input string tag, input int which, input int w, input logic [15:0] p[$],
                           input longint thr, input int max_gap, input int hold,
                           input longint anchor);
        longint es;
        bit eo;
        logic [63:0] s;
        logic f, o, v, r;
        model(w, p, es, eo);
        case (which)
            0: a_thr = 26'(thr);
            1: b_thr = 16'(thr);
            default: c_thr = 26'(thr);
        endcase
        foreach (p[i]) begin
            repeat ($urandom_range(0, max_gap)) tick();
            beat(which, p[i]);
        end
        observe(which, s, f, o, v, r);
        chk({tag, ":valid"}, 64'(v), 64'd1);
        chk({tag, ":in_ready"}, 64'(r), 64'd0);
        chk({tag, ":sum"}, s, 64'(es));
        chk({tag, ":fire"}, 64'(f), 64'(es >= thr));
        chk({tag, ":overflow"}, 64'(o), 64'(eo));
        if (anchor >= 0) chk({tag, ":sum_anchor"}, s, 64'(anchor));
        for (int k = 0; k < hold; k++) begin
            beat(which, 16'($urandom));
            observe(which, s, f, o, v, r);
            chk({tag, ":hold_valid"}, 64'(v), 64'd1);
            chk({tag, ":hold_sum"}, s, 64'(es));
            chk({tag, ":hold_in_ready"}, 64'(r), 64'd0);
        end
        set_ready(which, 1);
        tick();
        set_ready(which, 0);
        observe(which, s, f, o, v, r);
        chk({tag, ":rel_valid"}, 64'(v), 64'd0);
        chk({tag, ":rel_in_ready"}, 64'(r), 64'd1);
        chk({tag, ":rel_overflow"}, 64'(o), 64'd0);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [63:0] s;
        logic f, o, v, r;
        longint es;
        bit eo;

        // Reset state
        tick();
        observe(0, s, f, o, v, r);
        chk("rst:in_ready", 64'(r), 64'd1);
        chk("rst:out_valid", 64'(v), 64'd0);
        chk("rst:sum", s, 64'd0);
        chk("rst:fire", 64'(f), 64'd0);
        chk("rst:overflow", 64'(o), 64'd0);
        tick();
        reset_n = 1;
        tick();

        // Basic vector, fire at equality and just above
        q = '{16'd10, 16'd20, 16'd30, 16'd40};
        run_vec("basic100", 0, 26, q, 100, 0, 0, 100);
        run_vec("basic101", 0, 26, q, 101, 0, 0, 100);

        // Reset mid-vector (count=3) clears outputs asynchronously
        beat(0, 16'd5); beat(0, 16'd6); beat(0, 16'd7);
        reset_n = 0;
        #1;
        observe(0, s, f, o, v, r);
        chk("midrst:sum", s, 64'd0);
        chk("midrst:in_ready", 64'(r), 64'd1);
        chk("midrst:out_valid", 64'(v), 64'd0);
        tick();
        reset_n = 1;
        tick();
        run_vec("afterrst", 0, 26, q, 100, 0, 0, 100);

        // Gaps and 5 cycles of backpressure, then a second vector
        q = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_vec("gaps", 0, 26, q, 0, 3, 5, 10);
        q = '{16'd5, 16'd5, 16'd5, 16'd5};
        run_vec("second", 0, 26, q, 21, 0, 0, 20);

        // clear with a concurrent beat discards the partial sum
        beat(0, 16'd7); beat(0, 16'd7);
        a_clear = 1; a_prod = 16'd9; a_pv = 1;
        tick();
        a_clear = 0; a_pv = 0;
        chk("clr:in_ready", 64'(a_ir), 64'd1);
        q = '{16'd1, 16'd2, 16'd3, 16'd4};
        run_vec("clr_vec", 0, 26, q, 10, 1, 0, 10);

        // clear in DONE drops out_valid
        foreach (q[i]) beat(0, q[i]);
        chk("clrdone:valid_before", 64'(a_ov), 64'd1);
        a_clear = 1;
        tick();
        a_clear = 0;
        chk("clrdone:valid", 64'(a_ov), 64'd0);
        chk("clrdone:in_ready", 64'(a_ir), 64'd1);
        run_vec("clrdone_next", 0, 26, q, 11, 0, 0, 10);

        // Overflow on the 16-bit build, then a clean vector
        q = '{16'hFFFF, 16'h0002};
`ifdef ACCUM_SAT_EN
        run_vec("ovf", 1, 16, q, 0, 0, 1, 64'hFFFF);
`else
        run_vec("ovf", 1, 16, q, 0, 0, 1, 64'h0001);
`endif
        q = '{16'd1, 16'd1};
        run_vec("ovf_next", 1, 16, q, 3, 0, 0, 2);

        // Randomised vectors on both small builds
        for (int n = 0; n < 12; n++) begin
            q = {};
            for (int i = 0; i < 4; i++) q.push_back(16'($urandom));
            model(26, q, es, eo);
            run_vec("rand_a", 0, 26, q, ($urandom_range(0, 1) != 0) ? es : es + 1,
                    2, $urandom_range(0, 3), -1);
        end
        for (int n = 0; n < 12; n++) begin
            q = {};
            for (int i = 0; i < 2; i++) q.push_back(16'($urandom));
            run_vec("rand_b", 1, 16, q, longint'($urandom_range(0, 65535)),
                    2, $urandom_range(0, 2), -1);
        end

        // Full-size vector at the largest 8x8 product
        q = {};
        for (int i = 0; i < 784; i++) q.push_back(16'hFE01);
        run_vec("full", 2, 26, q, 0, 0, 0, 50979600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perceptron_accum.md
# perceptron_accum

Downstream stage of the 8×8 pixel-weight multiplier in the perceptron datapath. Consumes one registered 16-bit unsigned product per accepted beat, sums exactly NUM_INPUTS products into one neuron's dot product, then compares it against a threshold to produce the neuron's fire decision. Presents the result on a valid/ready output toward the classifier/argmax stage. Processes vectors back-to-back, one bubble cycle between them.

## Interface

- NUM_INPUTS, default 784: products per vector (28×28 image); minimum 2.
- ACC_W, default 26: accumulator width; 26 holds 784 × 65025 exactly; minimum 16.
- clk  in  1  rising-edge clock for all state.
- reset_n  in  1  asynchronous, active-low reset; clears all state and outputs immediately.
- clear  in  1  synchronous abort; discards the partial sum and returns to ACCUM with count 0.
- product  in  16  unsigned product from the multiplier.
- product_valid  in  1  product is valid this cycle; the controller aligns it with the multiplier's 1-cycle latency.
- in_ready  out  1  high when a product can be accepted; a beat transfers on product_valid & in_ready.
- threshold  in  ACC_W  unsigned fire threshold; must be stable from the first accepted beat until out_valid.
- sum  out  ACC_W  final dot product; held while out_valid.
- fire  out  1  sum >= threshold; held while out_valid.
- overflow  out  1  sticky per vector: the accumulator exceeded 2^ACC_W − 1.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  downstream accepts the result.

## Operation

- States: ACCUM (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
- ACCUM, accepted beat: acc ← acc + product, zero-extended to ACC_W; count++.
- Accepted beat with count == NUM_INPUTS−1 → DONE. Register sum = acc + product, fire = (that sum >= threshold), and overflow including that beat. Reset acc and count to 0.
- DONE: hold sum, fire and overflow. Ignore product_valid. On out_ready → ACCUM. overflow clears on that transition.
- clear has priority over product_valid and out_ready. It is honoured in either state: → ACCUM, acc=0, count=0, overflow=0, out_valid drops.
- Arithmetic: unsigned throughout. The wrap behaviour at 2^ACC_W is set under Configuration. overflow is set when the carry out of bit ACC_W−1 is 1 on any accepted beat of the vector.
- Out-of-range parameters (NUM_INPUTS < 2 or ACC_W < 16) are rejected at elaboration.

## Timing

- Reset values: in_ready=1 (state ACCUM), out_valid=0, sum=0, fire=0, overflow=0, acc=0, count=0.
- Accumulate: a beat accepted at edge t is visible in acc after edge t.
- Result latency: the final beat is accepted at edge t, so out_valid=1 and the final sum and fire are valid in the cycle after edge t.
- Backpressure: out_valid and all result outputs stay stable until the edge where out_ready=1. in_ready=1 from the following cycle onward, which gives one bubble per vector.
- Gaps: product_valid may drop at any time in ACCUM. acc and count hold.
- reset_n asserted mid-vector or in DONE: outputs go to reset values asynchronously. Deassertion is synchronised externally.

## Configuration

- ACCUM_SAT_EN defined: on a carry out, acc clamps to 2^ACC_W − 1 and stays there for the rest of the vector. fire is computed on the clamped value.
- ACCUM_SAT_EN undefined: acc wraps modulo 2^ACC_W.
- overflow behaves identically in both builds.

## Test plan

- Reset: pulse reset_n low during ACCUM with count=3 → next cycle in_ready=1, out_valid=0, sum=0, fire=0, overflow=0. A fresh vector then starts from count 0.
- Basic (NUM_INPUTS=4, threshold=100): products 10, 20, 30, 40 back-to-back with out_ready=1 → one cycle after the 4th beat: out_valid=1, sum=100, fire=1. Repeat with threshold=101 → fire=0.
- Backpressure and gaps (NUM_INPUTS=4): products 1, 2, 3, 4 with idle cycles between them; out_ready=0 for 5 cycles. → sum=10 held, in_ready=0, an extra product_valid beat is ignored. After out_ready=1, a second vector 5, 5, 5, 5 gives sum=20.
- Overflow (ACC_W=16, NUM_INPUTS=2): products 0xFFFF, 0x0002 → without ACCUM_SAT_EN: sum=0x0001, overflow=1. With ACCUM_SAT_EN: sum=0xFFFF, overflow=1. The next vector 1, 1 gives sum=2, overflow=0.
- clear (NUM_INPUTS=4): products 7, 7, then clear together with product_valid, then 1, 2, 3, 4 → sum=10. A clear asserted in DONE drops out_valid the next cycle.
- Full size (defaults): 784 products of 0xFE01 with threshold=0 → sum=50,979,600, fire=1, overflow=0.
